// File: rtl/parity_pkg.sv
// ----------------------------------------------------------------------------
// parity_pkg
//   Shared types and constants for the parity frame controller.
//   - DATA_W  : data word width
//   - CNT_W   : frame word-count width
//   - state_t : frame FSM states (IDLE, ACCUM, DONE)
//   - res_t   : registered frame result presented on the output side
// ----------------------------------------------------------------------------
package parity_pkg;

   localparam int DATA_W = 6;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] col;
      logic              par;
      logic [CNT_W-1:0]  cnt;
      logic              ovf;
   } res_t;

endpackage

// File: rtl/parity_word.sv
// ----------------------------------------------------------------------------
// parity_word
//   XOR reduction of one data word.
//   Ports:
//     data : input  [DATA_W-1:0] word to reduce
//     par  : output              ^data
// ----------------------------------------------------------------------------
module parity_word
   import parity_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   output logic              par
);

   assign par = ^data;

endmodule

// File: rtl/parity_frame_ctrl.sv
// ----------------------------------------------------------------------------
// parity_frame_ctrl
//   Accumulates column parity (bitwise XOR) over a frame of words and
//   presents a registered result until the consumer takes it.
//   A frame closes on in_last, or is force-closed at MAX_WORDS words
//   (out_ovf=1).
//
//   Parameters:
//     MAX_WORDS : maximum words per frame (2..255)
//     ODD_SEL   : 1 = out_par is ^out_col, 0 = out_par is ~^out_col
//
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     in_valid/in_ready     : input word handshake
//     in_data, in_last      : data word, frame-closing marker
//     out_valid/out_ready   : result handshake
//     out_col               : XOR of all words in the frame
//     out_par               : frame parity bit
//     out_cnt               : words accepted in the frame
//     out_ovf               : frame force-closed at MAX_WORDS
//
//   Build option PARITY_CHECK_EN adds:
//     in_exp  : expected column parity, sampled with the closing word
//     out_err : out_col != in_exp (always 1 on an overflow close)
// ----------------------------------------------------------------------------
module parity_frame_ctrl
   import parity_pkg::*;
#(
   parameter int MAX_WORDS = 16,
   parameter bit ODD_SEL   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
`ifdef PARITY_CHECK_EN
   input  logic [DATA_W-1:0] in_exp,
   output logic              out_err,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_col,
   output logic              out_par,
   output logic [CNT_W-1:0]  out_cnt,
   output logic              out_ovf
);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] col_acc, col_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              accept, at_limit, close, raw_par;
   res_t              res;

   // in_ready is gated by rst_n so nothing is taken while reset is held.
   assign in_ready = rst_n && (state != DONE);
   assign accept   = in_valid && in_ready;

   // First word of a frame reloads the accumulators instead of folding in.
   assign col_nxt  = (state == IDLE) ? in_data : (col_acc ^ in_data);
   assign cnt_nxt  = (state == IDLE) ? CNT_W'(1) : (cnt + CNT_W'(1));
   assign at_limit = (cnt_nxt == CNT_W'(MAX_WORDS));
   assign close    = accept && (in_last || at_limit);

   parity_word u_par (
      .data (col_nxt),
      .par  (raw_par)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = close ? DONE : ACCUM;
         ACCUM:   if (close)  state_nxt = DONE;
         DONE:    if (out_valid && out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_acc <= '0;
         cnt     <= '0;
         res     <= '{col: '0, par: ~ODD_SEL, cnt: '0, ovf: 1'b0};
      end else if (accept) begin
         col_acc <= col_nxt;
         cnt     <= cnt_nxt;
         if (close) begin
            res.col <= col_nxt;
            res.par <= ODD_SEL ? raw_par : ~raw_par;
            res.cnt <= cnt_nxt;
            // A close without in_last can only come from the count limit.
            res.ovf <= ~in_last;
         end
      end
   end

`ifdef PARITY_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      out_err <= 1'b0;
      else if (close)  out_err <= ~in_last | (col_nxt != in_exp);
   end
`endif

   assign out_valid = (state == DONE);
   assign out_col   = res.col;
   assign out_par   = res.par;
   assign out_cnt   = res.cnt;
   assign out_ovf   = res.ovf;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_parity_frame_ctrl
//   Self-checking bench for parity_frame_ctrl (MAX_WORDS=16, ODD_SEL=1).
//   Table frames plus hand sequences for overflow, back-pressure and reset.
//   Expected results are queued when a frame is driven and compared when
//   the DUT hands the result over.
// ----------------------------------------------------------------------------
module tb_parity_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, in_valid, in_last, out_ready;
   logic [5:0] in_data, in_exp;
   logic       in_ready, out_valid, out_par, out_ovf;
   logic [5:0] out_col;
   logic [7:0] out_cnt;
`ifdef PARITY_CHECK_EN
   logic       out_err;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0] col;
      logic       par;
      logic [7:0] cnt;
      logic       ovf;
      logic       err;
   } exp_t;

   typedef struct {
      int              n;
      logic [15:0][5:0] words;
      logic [5:0]      exp;
      exp_t            e;
   } vec_t;

   localparam int NV = 8;
   vec_t vec [NV];
   exp_t sb [$];
   exp_t got;

   parity_frame_ctrl #(.MAX_WORDS(16), .ODD_SEL(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
`ifdef PARITY_CHECK_EN
      .in_exp    (in_exp),
      .out_err   (out_err),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_col   (out_col),
      .out_par   (out_par),
      .out_cnt   (out_cnt),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Result monitor: a handshake is visible at the negedge before the
   // posedge that completes it.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         chk("sb_nonempty", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            got = sb.pop_front();
            chk("out_col", out_col, got.col);
            chk("out_par", out_par, got.par);
            chk("out_cnt", out_cnt, got.cnt);
            chk("out_ovf", out_ovf, got.ovf);
`ifdef PARITY_CHECK_EN
            chk("out_err", out_err, got.err);
`endif
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the word was taken.
   task automatic send_word(input logic [5:0] d, input logic l);
      int t = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic setv(input int k, input int n, input logic [5:0] a, b, c,
                       input logic [5:0] x, input logic [5:0] col,
                       input logic par, input int cnt, input logic err);
      vec[k].n        = n;
      vec[k].words    = '0;
      vec[k].words[0] = a;
      vec[k].words[1] = b;
      vec[k].words[2] = c;
      vec[k].exp      = x;
      vec[k].e        = '{col, par, cnt[7:0], 1'b0, err};
   endtask

   task automatic run_vec(input int k);
      sb.push_back(vec[k].e);
      in_exp = vec[k].exp;
      for (int i = 0; i < vec[k].n; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         send_word(vec[k].words[i], i == vec[k].n - 1);
      end
      @(negedge clk);
      chk("latency_valid", out_valid, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      in_exp = '0; out_ready = 1'b1;

      //    k  n  w0     w1     w2     exp    col    par   cnt err
      setv(0, 3, 6'h01, 6'h02, 6'h04, 6'h07, 6'h07, 1'b1, 3, 1'b0);
      setv(1, 1, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h3F, 1'b0, 1, 1'b1);
      setv(2, 2, 6'h15, 6'h2A, 6'h00, 6'h3F, 6'h3F, 1'b0, 2, 1'b0);
      setv(3, 3, 6'h10, 6'h10, 6'h33, 6'h33, 6'h33, 1'b0, 3, 1'b0);
      setv(4, 2, 6'h20, 6'h00, 6'h00, 6'h00, 6'h20, 1'b1, 2, 1'b1);
      setv(5, 2, 6'h0A, 6'h03, 6'h00, 6'h09, 6'h09, 1'b0, 2, 1'b0);
      setv(6, 2, 6'h0A, 6'h03, 6'h00, 6'h08, 6'h09, 1'b0, 2, 1'b1);
      // 16 words 0..15 with in_last on word 16: limit reached but no overflow
      setv(7, 16, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0, 16, 1'b0);
      for (int i = 0; i < 16; i++) vec[7].words[i] = 6'(i);

      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_col", out_col, 0);
      chk("rst_out_cnt", out_cnt, 0);
      chk("rst_out_ovf", out_ovf, 0);
      chk("rst_out_par", out_par, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int k = 0; k < NV; k++) run_vec(k);

      // Overflow: 16 words of 0x01, word 17 held against in_ready=0.
      out_ready = 1'b0;
      sb.push_back('{6'h00, 1'b0, 8'd16, 1'b1, 1'b1});
      in_exp = 6'h00;
      for (int i = 0; i < 16; i++) send_word(6'h01, 1'b0);
      in_valid = 1'b1; in_data = 6'h01; in_last = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("ovf_in_ready", in_ready, 0);
         chk("ovf_valid", out_valid, 1);
         chk("ovf_flag", out_ovf, 1);
         chk("ovf_cnt", out_cnt, 16);
      end
      @(posedge clk);
      #1 in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;

      // Back-pressure in DONE with a word waiting on the input.
      out_ready = 1'b0;
      sb.push_back('{6'h09, 1'b0, 8'd2, 1'b0, 1'b0});
      in_exp = 6'h09;
      send_word(6'h0A, 1'b0);
      send_word(6'h03, 1'b1);
      in_valid = 1'b1; in_data = 6'h2A; in_last = 1'b1; in_exp = 6'h2A;
      repeat (5) begin
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_col", out_col, 6'h09);
         chk("hold_cnt", out_cnt, 2);
         chk("hold_par", out_par, 0);
      end
      @(posedge clk);
      #1;
      sb.push_back('{6'h2A, 1'b1, 8'd1, 1'b0, 1'b0});
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("restart_in_ready", in_ready, 1);
      chk("restart_valid", out_valid, 0);
      @(posedge clk);
      #1 in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      chk("restart_latency", out_valid, 1);
      @(posedge clk);
      #1;

      // Reset in the middle of a frame discards it.
      send_word(6'h11, 1'b0);
      send_word(6'h22, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_col", out_col, 0);
      chk("mid_rst_cnt", out_cnt, 0);
      chk("mid_rst_ovf", out_ovf, 0);
      chk("mid_rst_par", out_par, 0);
`ifdef PARITY_CHECK_EN
      chk("mid_rst_err", out_err, 0);
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;
      sb.push_back('{6'h05, 1'b0, 8'd1, 1'b0, 1'b0});
      in_exp = 6'h05;
      send_word(6'h05, 1'b1);
      @(negedge clk);
      chk("post_rst_latency", out_valid, 1);
      @(posedge clk);
      #1;

      begin
         int t = 0;
         while (sb.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
         end
         chk("sb_drained", sb.size(), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/parity_frame_ctrl.md
PARITY_FRAME_CTRL -- requirements
Module: parity_frame_ctrl

Interface
REQ-001 Parameter MAX_WORDS, default 16, maximum words per frame (range 2..255).
REQ-002 Parameter ODD_SEL, default 1, frame parity polarity: 1 = odd (XOR reduction), 0 = even (inverted XOR reduction).
REQ-003 Port clk input 1 — single clock; all state updates on its rising edge.
REQ-004 Port rst_n input 1 — reset, asynchronous and active-low.
REQ-005 Port in_valid input 1 — the input word is valid.
REQ-006 Port in_ready output 1 — the block can accept a word.
REQ-007 Port in_data input 6 — data word.
REQ-008 Port in_last input 1 — this word closes the frame.
REQ-009 Port out_valid output 1 — the frame result is valid.
REQ-010 Port out_ready input 1 — the consumer accepts the result.
REQ-011 Port out_col output 6 — column parity, the bitwise XOR of all words in the frame.
REQ-012 Port out_par output 1 — frame parity bit, ^out_col when ODD_SEL=1 and ~^out_col when ODD_SEL=0.
REQ-013 Port out_cnt output 8 — number of words accepted in the frame.
REQ-014 Port out_ovf output 1 — the frame was force-closed at MAX_WORDS without in_last.

Function
REQ-015 The block SHALL implement a three-state FSM:
- IDLE -> ACCUM on the first accepted word, unless that word has in_last set, in which case IDLE -> DONE.
- ACCUM -> DONE on an accepted word with in_last, or on the accepted word that makes the count equal MAX_WORDS.
- DONE -> IDLE when out_valid && out_ready.
REQ-016 A word is accepted when in_valid && in_ready; in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-017 Each accepted word SHALL update col_acc <= col_acc ^ in_data and cnt <= cnt + 1 in the same cycle.
REQ-018 The first word of a frame SHALL load col_acc <= in_data and cnt <= 1, with no residue from the previous frame.
REQ-019 out_valid SHALL be 1 exactly while in DONE; it asserts the cycle after the closing word is accepted (latency 1).
REQ-020 out_col, out_par, out_cnt and out_ovf SHALL be registered and held stable throughout DONE regardless of out_ready.
REQ-021 out_ovf SHALL be 1 only when the frame closed on reaching the count limit with in_last=0.
- A word with in_last=1 that is also word number MAX_WORDS closes the frame with out_ovf=0.
REQ-022 In DONE, in_valid SHALL be ignored, the accumulators SHALL NOT change, and the next frame cannot start before the cycle after the handshake.
REQ-023 Input with in_valid=0 SHALL leave all state unchanged, so gaps between words inside a frame are allowed.

Reset
REQ-024 rst_n low SHALL immediately set:
- state = IDLE
- col_acc = 0, cnt = 0
- out_valid = 0, out_col = 0, out_cnt = 0, out_ovf = 0
- out_par = 0 when ODD_SEL=1, 1 when ODD_SEL=0
- in_ready = 0 while rst_n is low
REQ-025 Reset asserted mid-frame or in DONE SHALL discard the partial frame or result; no result is emitted for it.

Configuration
REQ-026 With PARITY_CHECK_EN defined, the block SHALL add:
- input in_exp (6 bits), sampled with the closing word
- output out_err (1 bit) = (out_col != in_exp), held and reset like the other outputs (reset value 0)
- on an overflow close, out_err = 1
REQ-027 Without PARITY_CHECK_EN, in_exp and out_err SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-028 The shared package parity_pkg SHALL hold:
- the FSM state enum (IDLE, ACCUM, DONE)
- the data width constant (6)
- the count width constant (8)
REQ-029 The single sub-module parity_word SHALL compute the 6-bit XOR reduction used for out_par.

Verification
REQ-030 Frame 0x01, 0x02, 0x04 (last on 0x04), out_ready=1 -> one cycle later out_col=0x07, out_par=1, out_cnt=3, out_ovf=0.
REQ-031 Single word 0x3F with in_last=1 -> IDLE->DONE; out_col=0x3F, out_par=0 (ODD_SEL=1), out_cnt=1.
REQ-032 17 words of 0x01 with no in_last, MAX_WORDS=16 -> close after word 16 with out_cnt=16, out_col=0x00, out_ovf=1; in_ready=0 while word 17 is held.
REQ-033 out_ready=0 for 5 cycles in DONE, in_valid=1 -> outputs stable, in_ready=0, no word accepted; the next frame starts the cycle after the handshake.
REQ-034 rst_n pulsed low after 2 words of a frame -> outputs return to reset values; the next frame 0x05 (last) gives out_col=0x05, out_cnt=1.
REQ-035 With PARITY_CHECK_EN defined: frame 0x0A, 0x03, in_exp=0x09 -> out_err=0; repeating with in_exp=0x08 -> out_err=1.
